// File: rtl/dsss_tx_scheduler.sv
// dsss_tx_scheduler
//   Shares one DSSS/CDMA transmit chain between two requesters. Whole frames
//   are granted round-robin. The granted DATA_W-bit payload is shifted out MSB
//   first, and each bit is held for CHIPS_PER_BIT clocks. After each frame the
//   block waits GUARD_CYCLES idle clocks before it issues another grant.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_enable          1 = new grants allowed (a frame in flight always completes)
//   i_req_valid[1:0]  per-user frame request
//   i_req_data0/1     per-user payload, captured on handshake
//   o_req_ready[1:0]  one-hot combinational accept, only in IDLE
//   o_tx_bit          current data bit to the transmitter data_in
//   o_tx_user         code select to the transmitter user_select
//   o_tx_active       high while a frame is being chipped out
//   o_frame_done      1-cycle pulse the cycle after the last chip
//   o_done_user       user of the completed frame, valid with o_frame_done
module dsss_tx_scheduler #(
  parameter int DATA_W        = 16,
  parameter int CHIPS_PER_BIT = 6,
  parameter int GUARD_CYCLES  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [1:0]        i_req_valid,
  input  logic [DATA_W-1:0] i_req_data0,
  input  logic [DATA_W-1:0] i_req_data1,
  output logic [1:0]        o_req_ready,
  output logic              o_tx_bit,
  output logic              o_tx_user,
  output logic              o_tx_active,
  output logic              o_frame_done,
  output logic              o_done_user
);

  localparam int CW = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1)        ? $clog2(DATA_W)        : 1;
  localparam int GW = (GUARD_CYCLES > 1)  ? $clog2(GUARD_CYCLES)  : 1;
  localparam logic [CW-1:0] CHIP_LAST  = CW'(CHIPS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shreg;
  logic [CW-1:0]     r_chip_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [GW-1:0]     r_guard_cnt;
  logic              r_tx_user;
  logic              r_last_grant;
  logic              r_frame_done;

  logic w_grant, w_hs, w_last_chip;

  // Round robin only matters when both users request; otherwise the sole
  // requester wins. rst masks the accept so that no transfer is seen while
  // reset is asserted.
  assign w_grant     = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];
  assign w_hs        = (r_state == S_IDLE) && i_enable && (|i_req_valid) && !rst;
  assign w_last_chip = (r_state == S_SEND) && (r_chip_cnt == CHIP_LAST) &&
                       (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next      = S_SEND;
          o_req_ready = w_grant ? 2'b10 : 2'b01;
        end
      end
      // With no guard the frame_done cycle is already IDLE and can accept.
      S_SEND:  if (w_last_chip) w_next = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
      S_GUARD: if (r_guard_cnt == GUARD_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_chip_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_guard_cnt  <= '0;
      r_tx_user    <= 1'b0;
      r_last_grant <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_chip;
      // Guard is counted from the frame_done cycle, which is its first cycle.
      r_guard_cnt  <= (r_state == S_GUARD) ? r_guard_cnt + 1'b1 : '0;
      if (w_hs) begin
        r_shreg      <= w_grant ? i_req_data1 : i_req_data0;
        r_chip_cnt   <= '0;
        r_bit_cnt    <= '0;
        r_tx_user    <= w_grant;
        r_last_grant <= w_grant;
      end else if (r_state == S_SEND) begin
        if (r_chip_cnt == CHIP_LAST) begin
          r_chip_cnt <= '0;
          r_bit_cnt  <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
          r_shreg    <= r_shreg << 1;
        end else begin
          r_chip_cnt <= r_chip_cnt + 1'b1;
        end
      end
    end
  end

  assign o_tx_active  = (r_state == S_SEND);
  assign o_tx_bit     = o_tx_active & r_shreg[DATA_W-1];
  assign o_tx_user    = r_tx_user;
  assign o_frame_done = r_frame_done;
  assign o_done_user  = r_frame_done & r_tx_user;

endmodule
